// File: rtl/branch_predictor_pkg.sv
// Shared constants for the dynamic branch predictor.
// 2-bit counter states and the counter reset value.
package branch_predictor_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  localparam logic [1:0] BP_CTR_RST = BP_WNT;

endpackage

// File: rtl/bp_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Pure combinational; used on the predictor update path.
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // step toward the outcome, holding at ST / SNT
  always_comb begin
    ctr_next = ctr;
    unique case (1'b1)
      taken && (ctr != BP_ST):   ctr_next = ctr + 2'd1;
      !taken && (ctr != BP_SNT): ctr_next = ctr - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit BHT branch predictor, optional gshare indexing.
// Define BP_GSHARE_EN to xor global history into the BHT index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_LEN  = 8,
  parameter int GHR_LEN  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] pred_pc,
  output logic                pred_taken,
  output logic [DATA_LEN-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [DATA_LEN-1:0] upd_pc,
  input  logic                upd_is_br,
  input  logic                upd_is_jal,
  input  logic                upd_taken,
  input  logic [DATA_LEN-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count
);

  localparam int IDX_LEN = $clog2(ENTRIES);

  typedef struct packed {
    logic                valid;
    logic                jal;
    logic [TAG_LEN-1:0]  tag;
    logic [DATA_LEN-1:0] tgt;
  } btb_t;

  btb_t        btb_q [ENTRIES];
  btb_t        btb_d [ENTRIES];
  logic [1:0]  bht_q [ENTRIES];
  logic [1:0]  bht_d [ENTRIES];
  logic [31:0] br_count_q;
  logic [31:0] br_count_d;
  logic [31:0] mispred_count_q;
  logic [31:0] mispred_count_d;

  logic [IDX_LEN-1:0] hist;
  logic [IDX_LEN-1:0] p_idx;
  logic [IDX_LEN-1:0] p_bidx;
  logic [IDX_LEN-1:0] u_idx;
  logic [IDX_LEN-1:0] u_bidx;
  logic [TAG_LEN-1:0] p_tag;
  logic [TAG_LEN-1:0] u_tag;
  btb_t               p_ent;
  logic               p_hit;
  logic               bht_wr;
  logic [1:0]         ctr_next;

  function automatic logic [IDX_LEN-1:0] idx_of(
    input logic [DATA_LEN-1:0] pc
  );
    return pc[IDX_LEN+1:2];
  endfunction

  function automatic logic [TAG_LEN-1:0] tag_of(
    input logic [DATA_LEN-1:0] pc
  );
    return pc[TAG_LEN+IDX_LEN+1:IDX_LEN+2];
  endfunction

`ifdef BP_GSHARE_EN
  logic [GHR_LEN-1:0] ghr_q;
  logic [GHR_LEN-1:0] ghr_d;

  assign hist = IDX_LEN'(ghr_q);

  // history advances only when a conditional branch resolves
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && bht_wr) begin
      ghr_d = GHR_LEN'({ghr_q, upd_taken});
    end
  end

  // global history register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  localparam int unused_ghr_len = GHR_LEN;
  assign hist = '0;
`endif

  logic unused_pc;
  assign unused_pc = ^{pred_pc, upd_pc};

  assign p_idx  = idx_of(pred_pc);
  assign p_tag  = tag_of(pred_pc);
  assign p_bidx = p_idx ^ hist;
  assign p_ent  = btb_q[p_idx];
  assign p_hit  = p_ent.valid && (p_ent.tag == p_tag);

  assign pred_taken  = p_hit && (p_ent.jal || bht_q[p_bidx][1]);
  assign pred_target = pred_taken ? p_ent.tgt
                                  : pred_pc + DATA_LEN'(4);

  assign u_idx  = idx_of(upd_pc);
  assign u_tag  = tag_of(upd_pc);
  assign u_bidx = u_idx ^ hist;
  assign bht_wr = upd_is_br && !upd_is_jal;

  bp_sat_counter2 u_ctr (
    .ctr      (bht_q[u_bidx]),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  // training: counters on branches, BTB on taken outcomes
  always_comb begin
    btb_d           = btb_q;
    bht_d           = bht_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_valid) begin
      br_count_d = br_count_q + 32'd1;
      if (upd_mispredict) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end
      if (bht_wr) begin
        bht_d[u_bidx] = ctr_next;
      end
      if (upd_taken) begin
        btb_d[u_idx] = '{valid: 1'b1,
                         jal:   upd_is_jal,
                         tag:   u_tag,
                         tgt:   upd_target};
      end
    end
  end

  // table and statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        bht_q[i] <= BP_CTR_RST;
      end
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      btb_q           <= btb_d;
      bht_q           <= bht_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// Reference model feeds a scoreboard checked on the falling edge.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_br;
  logic        upd_is_jal;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] tk;
    logic [31:0] tgt;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t sb[$];

  bit [1:0]  m_ctr [64];
  bit        m_v   [64];
  bit        m_j   [64];
  bit [7:0]  m_tag [64];
  bit [31:0] m_tgt [64];
  bit [5:0]  m_ghr;
  bit [31:0] m_br;
  bit [31:0] m_mis;

  branch_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_br      (upd_is_br),
    .upd_is_jal     (upd_is_jal),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 2'b01;
      m_v[i]   = 1'b0;
      m_j[i]   = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    m_ghr = '0;
    m_br  = '0;
    m_mis = '0;
  endtask

  function automatic bit [5:0] m_bidx(input bit [5:0] idx);
`ifdef BP_GSHARE_EN
    return idx ^ m_ghr;
`else
    return idx;
`endif
  endfunction

  task automatic m_pred(input  logic [31:0] pc,
                        output bit          tk,
                        output logic [31:0] tgt);
    bit [5:0] idx;
    bit       hit;
    idx = pc[7:2];
    hit = m_v[idx] && (m_tag[idx] == pc[15:8]);
    tk  = hit && (m_j[idx] || m_ctr[m_bidx(idx)][1]);
    tgt = tk ? m_tgt[idx] : pc + 32'd4;
  endtask

  // one cycle: lookup lpc (pre-update state), optional update
  task automatic step(input logic [31:0] lpc,
                      input bit          uv,
                      input logic [31:0] upc,
                      input bit          br,
                      input bit          jal,
                      input bit          tk,
                      input logic [31:0] tgt);
    bit          ptk;
    logic [31:0] ptgt;
    bit          mis;
    bit [5:0]    idx;
    bit [5:0]    bi;
    @(posedge clk);
    #1;
    pred_pc = lpc;
    m_pred(lpc, ptk, ptgt);
    sb.push_back('{tk: {31'd0, ptk}, tgt: ptgt,
                   br: m_br, mis: m_mis});
    m_pred(upc, ptk, ptgt);
    mis = (ptk != tk) || (tk && (ptgt != tgt));
    upd_valid      = uv;
    upd_pc         = upc;
    upd_is_br      = br;
    upd_is_jal     = jal;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mis;
    if (uv) begin
      m_br++;
      if (mis) m_mis++;
      idx = upc[7:2];
      bi  = m_bidx(idx);
      if (br && !jal) begin
        if (tk && m_ctr[bi] != 2'b11)  m_ctr[bi]++;
        if (!tk && m_ctr[bi] != 2'b00) m_ctr[bi]--;
        m_ghr = {m_ghr[4:0], tk};
      end
      if (tk) begin
        m_v[idx]   = 1'b1;
        m_j[idx]   = jal;
        m_tag[idx] = upc[15:8];
        m_tgt[idx] = tgt;
      end
    end
  endtask

  task automatic look(input logic [31:0] pc);
    step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic beq(input logic [31:0] pc,
                     input bit          tk,
                     input logic [31:0] tgt);
    step(pc, 1'b1, pc, 1'b1, 1'b0, tk, tgt);
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_taken",  {31'd0, pred_taken}, e.tk);
      chk("sb_target", pred_target,         e.tgt);
      chk("sb_br",     br_count,            e.br);
      chk("sb_mis",    mispred_count,       e.mis);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mis_mid;
    logic [31:0] delta;
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    pred_pc        = 32'h100;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_is_br      = 1'b0;
    upd_is_jal     = 1'b0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    m_reset();
    #2;
    chk("rst_taken",  {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target,         32'h104);
    chk("rst_br",     br_count,            32'd0);
    chk("rst_mis",    mispred_count,       32'd0);
    #10;
    reset = 1'b1;

    beq(32'h100, 1'b1, 32'h80);
    look(32'h100);
    #2;
    chk("beq_t1_taken",  {31'd0, pred_taken}, 32'd1);
    chk("beq_t1_target", pred_target,         32'h80);
    beq(32'h100, 1'b1, 32'h80);
    beq(32'h100, 1'b0, 32'h80);
    look(32'h100);
    beq(32'h100, 1'b0, 32'h80);
    look(32'h100);
    #2;
    chk("beq_wnt_taken",  {31'd0, pred_taken}, 32'd0);
    chk("beq_wnt_target", pred_target,         32'h104);

    for (int i = 0; i < 3; i++) beq(32'h100, 1'b1, 32'h80);
    for (int i = 0; i < 6; i++) beq(32'h100, 1'b0, 32'h80);
    beq(32'h100, 1'b1, 32'h80);
    look(32'h100);
    #2;
    chk("sat_low_taken", {31'd0, pred_taken}, 32'd0);
    beq(32'h100, 1'b1, 32'h80);
    look(32'h100);
    #2;
    chk("sat_up_taken", {31'd0, pred_taken}, 32'd1);

    step(32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400);
    look(32'h200);
    #2;
    chk("jal_taken",  {31'd0, pred_taken}, 32'd1);
    chk("jal_target", pred_target,         32'h400);
    look(32'h300);
    #2;
    chk("alias_taken",  {31'd0, pred_taken}, 32'd0);
    chk("alias_target", pred_target,         32'h304);

    step(32'h500, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 32'h0);
    step(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h88);
    look(32'h100);

    mis_mid = '0;
    for (int i = 0; i < 32; i++) begin
      beq(32'h300, (i % 2) == 0, 32'h340);
      if (i == 15) mis_mid = m_mis;
    end
    look(32'h300);
    @(negedge clk);
    #1;
    delta = mispred_count - mis_mid;
`ifdef BP_GSHARE_EN
    chk("gshare_steady", delta, 32'd0);
`else
    chk("bimodal_alt", {31'd0, delta >= 32'd8}, 32'd1);
`endif

    pred_pc    = 32'h100;
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_is_br  = 1'b1;
    upd_is_jal = 1'b0;
    upd_taken  = 1'b1;
    upd_target = 32'h90;
    reset      = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_taken",  {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_target", pred_target,         32'h104);
    chk("mid_rst_br",     br_count,            32'd0);
    chk("mid_rst_mis",    mispred_count,       32'd0);
    @(negedge clk);
    #1;
    chk("hold_rst_br",    br_count,            32'd0);
    chk("hold_rst_taken", {31'd0, pred_taken}, 32'd0);
    upd_valid = 1'b0;
    reset     = 1'b1;

    beq(32'h100, 1'b1, 32'h90);
    look(32'h100);
    look(32'h100);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RV32I core: a direct-mapped BTB plus a table of 2-bit saturating counters, with optional gshare indexing. Looked up combinationally with the IF-stage PC to steer next-PC selection. Trained from the EX stage once a branch or JAL resolves. Replaces the current "stall IF on every branch" policy with predict-and-flush; the core flushes on `upd_mispredict`.

## Interface
- `DATA_LEN`, 32: PC/target width.
- `ENTRIES`, 64: BTB and BHT depth; a power of 2, ≥4. `IDX_LEN = log2(ENTRIES)`.
- `TAG_LEN`, 8: stored tag width; `TAG_LEN + IDX_LEN + 2 ≤ DATA_LEN`.
- `GHR_LEN`, 6: global history length, ≤ `IDX_LEN`; used only with `BP_GSHARE_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pred_pc`  in  DATA_LEN  IF-stage PC.
- `pred_taken`  out  1  predicted taken.
- `pred_target`  out  DATA_LEN  predicted next PC.
- `upd_valid`  in  1  one resolved control-flow instruction this cycle.
- `upd_pc`  in  DATA_LEN  PC of the resolved instruction.
- `upd_is_br`  in  1  conditional branch (BEQ..BGEU).
- `upd_is_jal`  in  1  JAL.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  DATA_LEN  actual taken target (ALU output).
- `upd_mispredict`  in  1  direction or target was mispredicted.
- `br_count`  out  32  resolved-update counter.
- `mispred_count`  out  32  mispredict counter.

## Operation
- Index `idx = pc[IDX_LEN+1:2]`. Tag `= pc[TAG_LEN+IDX_LEN+1:IDX_LEN+2]`.
- BTB entry: valid, tag, target, is_jal. BHT entry: 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup (combinational from registered tables): `hit = valid[idx] && tag match`.
  - If `hit && (is_jal || ctr[bht_idx][1])`: `pred_taken=1` and `pred_target=btb target`.
  - Otherwise: `pred_taken=0` and `pred_target=pred_pc+4`, mod 2^DATA_LEN.
- Update, when `upd_valid` is high:
  - BHT: if `upd_is_br`, the counter at `bht_idx(upd_pc)` increments when taken and decrements when not taken. It saturates at 11 and 00.
  - BTB: if `upd_taken`, write valid=1, tag, `upd_target`, and `is_jal=upd_is_jal`, overwriting any alias.
  - A not-taken outcome never allocates or invalidates a BTB entry.
  - `br_count` increments on every update. `mispred_count` increments when `upd_mispredict` is also high. Both wrap at 2^32.
- When `upd_valid` is low, no state changes.
- If `upd_is_br` and `upd_is_jal` are both high, `upd_is_jal` wins and the BHT is not touched.

## Timing
- Lookup has zero-cycle latency; `pred_*` is a pure function of `pred_pc` and the current table state.
- An update becomes visible to lookup on the cycle after its rising edge. There is no write-to-read bypass.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update contents.
- Reset (asynchronous, `reset`=0), taking effect immediately, even mid-operation:
  - all BTB valid bits cleared;
  - all counters set to 01;
  - GHR set to 0;
  - both stat counters set to 0.
- Outputs while in reset: `pred_taken=0`, `pred_target=pred_pc+4`, `br_count=0`, `mispred_count=0`.
- First update accepted on the first rising edge after `reset` deasserts.

## Configuration
- `BP_GSHARE_EN` defined:
  - `bht_idx = idx ^ {zero-extended GHR}`; the BTB still uses plain `idx`.
  - On each update with `upd_is_br` (and not `upd_is_jal`), GHR shifts left and inserts `upd_taken` at bit 0.
  - The GHR is non-speculative: it advances only at resolution.
- `BP_GSHARE_EN` undefined: `bht_idx = idx`. No GHR register exists, and `GHR_LEN` is ignored.

## Structure
- Shared package/defines: counter state constants (`BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`) and the counter reset value `BP_WNT`.
- One sub-module, `bp_sat_counter2`: a pure combinational next-state function (`ctr`, `taken` → `ctr_next`), instantiated once on the update path.
- Tables are register arrays in `branch_predictor`; no memory macro.

## Test plan
- Reset, then any `pred_pc` (e.g. 0x100) → `pred_taken=0`, `pred_target=0x104`, both counts 0.
- BEQ at 0x100, target 0x80, updated taken twice:
  - after the first update the counter is 10 → predict taken, target 0x80;
  - after the second update it is 11; one not-taken update → 10, still taken;
  - a second not-taken → 01, predict not-taken, target 0x104.
- Saturation: five not-taken updates from 11 → counter 00. A further not-taken keeps 00; one taken → 01.
- JAL at 0x200, target 0x400, single update → next-cycle lookup gives taken/0x400 regardless of counter. Alias PC 0x200+ENTRIES*4 → tag miss, not taken.
- Same-cycle update and lookup of 0x100 → old prediction this cycle, new prediction next cycle. Assert `reset`=0 mid-stream → immediate return to reset outputs and counts 0.
- With `BP_GSHARE_EN`: alternating T/N branch at 0x300, after warm-up:
  - prediction matches the outcome every iteration, and `mispred_count` stops increasing.
  - Without the macro, the same stream mispredicts at least every other iteration.
